complex_subtractor_pipe: RTL and testbench

- Two-stage pipelined complex subtractor computing a − b on signed real/imag operands, with per-sample overflow detection and selectable saturation or wrap.
- Provides the difference leg of the radix-2 butterfly in the MultimodeFFT datapath. It is the counterpart of the combinational complex_adder.
- Uses a valid/ready stream handshake on input and output, so it tolerates backpressure from downstream twiddle-multiply and memory stages.

---
 rtl/complex_subtractor_pipe.sv | 101 ++++++++++
 tb/tb_complex_subtractor_pipe.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/complex_subtractor_pipe.sv
// complex_subtractor_pipe: two-stage pipelined complex subtractor (a - b).
// Stage 1 forms the WIDTH+1-bit sign-extended differences. Stage 2 detects
// overflow, then saturates or wraps the result. The two stages form a 2-deep
// valid/ready pipeline, and a saturating counter tracks overflowed output beats.
module complex_subtractor_pipe #(
  parameter int WIDTH     = 16,
  parameter bit SATURATE  = 1'b1,
  parameter int CNT_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [WIDTH-1:0]     a_real,
  input  logic signed [WIDTH-1:0]     a_imag,
  input  logic signed [WIDTH-1:0]     b_real,
  input  logic signed [WIDTH-1:0]     b_imag,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [WIDTH-1:0]     diff_real,
  output logic signed [WIDTH-1:0]     diff_imag,
  output logic                        overflow,
  output logic        [CNT_WIDTH-1:0] ovf_count,
  input  logic                        ovf_clear
);

  localparam logic [WIDTH-1:0]     MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0]     MAX_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic             s1_valid;
  logic             s2_valid;
  logic             s1_en;
  logic             s2_en;
  logic [WIDTH:0]   s1_dr;
  logic [WIDTH:0]   s1_di;
  logic             ovf_r;
  logic             ovf_i;
  logic [WIDTH-1:0] res_r;
  logic [WIDTH-1:0] res_i;

  // Advance stage 2 when it is empty or draining. A stage-1 bubble may be
  // overwritten even while stage 2 stalls.
  assign s2_en     = !s2_valid || out_ready;
  assign s1_en     = !s1_valid || s2_en;
  assign in_ready  = s1_en;
  assign out_valid = s2_valid;

  // Overflow detection plus saturation or wrap of the stage-1 differences.
  always_comb begin
    ovf_r = s1_dr[WIDTH] ^ s1_dr[WIDTH-1];
    ovf_i = s1_di[WIDTH] ^ s1_di[WIDTH-1];
    res_r = s1_dr[WIDTH-1:0];
    res_i = s1_di[WIDTH-1:0];
    if (SATURATE && ovf_r) res_r = s1_dr[WIDTH] ? MAX_NEG : MAX_POS;
    if (SATURATE && ovf_i) res_i = s1_di[WIDTH] ? MAX_NEG : MAX_POS;
  end

  // Stage 1: capture the valid bit and the sign-extended differences.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_dr    <= '0;
      s1_di    <= '0;
    end else if (s1_en) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_dr <= {a_real[WIDTH-1], a_real} - {b_real[WIDTH-1], b_real};
        s1_di <= {a_imag[WIDTH-1], a_imag} - {b_imag[WIDTH-1], b_imag};
      end
    end
  end

  // Stage 2: register the result and the overflow flag. The flag is gated by
  // valid, so a bubble never carries a stale flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid  <= 1'b0;
      diff_real <= '0;
      diff_imag <= '0;
      overflow  <= 1'b0;
    end else if (s2_en) begin
      s2_valid  <= s1_valid;
      diff_real <= res_r;
      diff_imag <= res_i;
      overflow  <= s1_valid & (ovf_r | ovf_i);
    end
  end

  // Saturating count of overflowed beats accepted downstream. Clear wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_count <= '0;
    end else if (ovf_clear) begin
      ovf_count <= '0;
    end else if (s2_valid && out_ready && overflow && (ovf_count != '1)) begin
      ovf_count <= ovf_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_complex_subtractor_pipe.sv
// Self-checking bench for complex_subtractor_pipe. It drives three instances
// in parallel from the same stimulus:
//   u0: SATURATE=1, CNT_WIDTH=16
//   u1: SATURATE=0, CNT_WIDTH=16
//   u2: SATURATE=1, CNT_WIDTH=4
// A per-instance scoreboard holds the expected results. Entries are pushed when
// an input transfer is seen and popped when an output transfer is seen.
module tb_complex_subtractor_pipe;

  typedef struct {
    int dr;
    int di;
    bit ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic ovf_clear = 1'b0;
  logic signed [15:0] a_real = '0, a_imag = '0, b_real = '0, b_imag = '0;

  logic               rdy_w  [3];
  logic               vld_w  [3];
  logic signed [15:0] dr_w   [3];
  logic signed [15:0] di_w   [3];
  logic               ovf_w  [3];
  logic        [15:0] cnt0, cnt1;
  logic        [3:0]  cnt2;
  int                 cnt_w  [3];

  int   checks = 0;
  int   errors = 0;
  exp_t sb [3][$];
  int   mcnt [3];
  bit   sat_p [3] = '{1'b1, 1'b0, 1'b1};
  int   cmax  [3] = '{65535, 65535, 15};
  bit   rnd_done;

  always #5 clk = ~clk;

  complex_subtractor_pipe #(.WIDTH(16), .SATURATE(1'b1), .CNT_WIDTH(16)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_w[0]),
    .a_real(a_real), .a_imag(a_imag), .b_real(b_real), .b_imag(b_imag),
    .out_valid(vld_w[0]), .out_ready(out_ready), .diff_real(dr_w[0]),
    .diff_imag(di_w[0]), .overflow(ovf_w[0]), .ovf_count(cnt0), .ovf_clear(ovf_clear));

  complex_subtractor_pipe #(.WIDTH(16), .SATURATE(1'b0), .CNT_WIDTH(16)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_w[1]),
    .a_real(a_real), .a_imag(a_imag), .b_real(b_real), .b_imag(b_imag),
    .out_valid(vld_w[1]), .out_ready(out_ready), .diff_real(dr_w[1]),
    .diff_imag(di_w[1]), .overflow(ovf_w[1]), .ovf_count(cnt1), .ovf_clear(ovf_clear));

  complex_subtractor_pipe #(.WIDTH(16), .SATURATE(1'b1), .CNT_WIDTH(4)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_w[2]),
    .a_real(a_real), .a_imag(a_imag), .b_real(b_real), .b_imag(b_imag),
    .out_valid(vld_w[2]), .out_ready(out_ready), .diff_real(dr_w[2]),
    .diff_imag(di_w[2]), .overflow(ovf_w[2]), .ovf_count(cnt2), .ovf_clear(ovf_clear));

  assign cnt_w[0] = int'(cnt0);
  assign cnt_w[1] = int'(cnt1);
  assign cnt_w[2] = int'(cnt2);

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference arithmetic in plain integers, then fit to 16 bits.
  function automatic void fit(input int d, input bit sat, output int r, output bit o);
    o = (d > 32767) || (d < -32768);
    if (!o)      r = d;
    else if (sat) r = (d > 0) ? 32767 : -32768;
    else         r = (d > 0) ? d - 65536 : d + 65536;
  endfunction

  function automatic exp_t model(input bit sat);
    exp_t e;
    bit   o_r, o_i;
    fit(int'(a_real) - int'(b_real), sat, e.dr, o_r);
    fit(int'(a_imag) - int'(b_imag), sat, e.di, o_i);
    e.ovf = o_r | o_i;
    return e;
  endfunction

  // Monitor, sampled on the falling edge. Inputs are driven just after the
  // rising edge, so the handshake signals seen here decide the next edge.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        bit xfer_ovf;
        xfer_ovf = 1'b0;
        check($sformatf("u%0d_ovf_count", i), cnt_w[i], mcnt[i]);
        if (vld_w[i]) begin
          if (sb[i].size() == 0) begin
            check($sformatf("u%0d_spurious_out_valid", i), 1, 0);
          end else begin
            check($sformatf("u%0d_diff_real", i), int'(dr_w[i]), sb[i][0].dr);
            check($sformatf("u%0d_diff_imag", i), int'(di_w[i]), sb[i][0].di);
            check($sformatf("u%0d_overflow", i), int'(ovf_w[i]), int'(sb[i][0].ovf));
            if (out_ready) begin
              xfer_ovf = sb[i][0].ovf;
              void'(sb[i].pop_front());
            end
          end
        end
        if (ovf_clear)                        mcnt[i] = 0;
        else if (xfer_ovf && mcnt[i] < cmax[i]) mcnt[i] = mcnt[i] + 1;
        if (in_valid && rdy_w[i]) sb[i].push_back(model(sat_p[i]));
      end
    end
  end

  // Present one beat and hold it until u0 accepts it. The task returns just
  // after the accepting edge with in_valid low.
  task automatic send(input int ar, input int ai, input int br, input int bi);
    int n;
    a_real = 16'(ar); a_imag = 16'(ai); b_real = 16'(br); b_imag = 16'(bi);
    in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (rdy_w[0]) break;
      if (++n > 200) begin
        check("send_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb[0].size() + sb[1].size() + sb[2].size()) != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", int'(n >= 200), 0);
    @(posedge clk); #1;
  endtask

  // Called right after send(): the output must be absent after one edge and
  // present after the second.
  task automatic latency_check(input string tag, input int exp_dr);
    @(negedge clk);
    check({tag, "_valid_lat1"}, int'(vld_w[0]), 0);
    @(negedge clk);
    check({tag, "_valid_lat2"}, int'(vld_w[0]), 1);
    check({tag, "_dr_lat2"}, int'(dr_w[0]), exp_dr);
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) mcnt[i] = 0;
    #2;
    check("rst_out_valid", int'(vld_w[0]), 0);
    check("rst_overflow", int'(ovf_w[0]), 0);
    check("rst_diff_real", int'(dr_w[0]), 0);
    check("rst_diff_imag", int'(di_w[1]), 0);
    check("rst_ovf_count", cnt_w[2], 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("in_ready_after_rst", int'(rdy_w[0]), 1);

    // Basic beat, with a latency check.
    out_ready = 1'b1;
    send(16384, -100, 16384, 50);
    @(negedge clk);
    check("basic_valid_lat1", int'(vld_w[0]), 0);
    @(negedge clk);
    check("basic_valid_lat2", int'(vld_w[0]), 1);
    check("basic_diff_real", int'(dr_w[0]), 0);
    check("basic_diff_imag", int'(di_w[0]), -150);
    check("basic_overflow", int'(ovf_w[0]), 0);
    @(posedge clk); #1;
    drain();

    // Positive saturation (real) and negative saturation (imag).
    send(32767, -32768, -16384, 1);
    drain();
    check("sat_ovf_count", cnt_w[0], 1);

    // Wrap cases plus edge operands.
    send(32767, 0, -1, 0);
    send(0, 0, -32768, 0);
    send(-32768, -32768, -32768, -32768);
    send(0, -32768, -32768, 0);
    drain();

    // Backpressure: both stages fill, in_ready drops, outputs hold.
    out_ready = 1'b0;
    send(1, 0, 0, 0);
    send(2, 0, 0, 0);
    a_real = 16'sd3; in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("bp_in_ready_low", int'(rdy_w[0]), 0);
      check("bp_hold_valid", int'(vld_w[0]), 1);
      check("bp_hold_diff_real", int'(dr_w[0]), 1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(3, 0, 0, 0);
    send(4, 0, 0, 0);
    send(5, 0, 0, 0);
    drain();

    // Counter saturation: 20 overflowing beats. u2 stops at 15.
    for (int k = 0; k < 20; k++) send(32767, 0, -1, 0);
    drain();
    check("cnt4_saturated", cnt_w[2], 15);

    // Clear coincident with an overflowing output transfer.
    send(32767, 0, -1, 0);
    @(posedge clk); #1 ovf_clear = 1'b1;
    @(negedge clk);
    check("clr_coincident_xfer", int'(vld_w[0] && ovf_w[0]), 1);
    @(posedge clk); #1 ovf_clear = 1'b0;
    check("clr_wins_u0", cnt_w[0], 0);
    check("clr_wins_u2", cnt_w[2], 0);
    drain();

    // Random traffic under random backpressure.
    rnd_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 60; k++) begin
          int ar, br;
          ar = (k % 7 == 0) ? 32767 : int'($urandom_range(0, 65535)) - 32768;
          br = (k % 5 == 0) ? -32768 : int'($urandom_range(0, 65535)) - 32768;
          send(ar, int'($urandom_range(0, 65535)) - 32768, br,
               int'($urandom_range(0, 65535)) - 32768);
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain();

    // Reset mid-stream with both stages full and a non-zero count.
    send(32767, 0, -1, 0);
    drain();
    out_ready = 1'b0;
    send(7, 0, 0, 0);
    send(8, 0, 0, 0);
    #3 rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sb[i].delete();
      mcnt[i] = 0;
    end
    #1;
    check("midrst_out_valid_u0", int'(vld_w[0]), 0);
    check("midrst_out_valid_u1", int'(vld_w[1]), 0);
    check("midrst_ovf_count_u0", cnt_w[0], 0);
    check("midrst_ovf_count_u2", cnt_w[2], 0);
    @(posedge clk); #1 rst = 1'b0;
    check("midrst_in_ready", int'(rdy_w[0]), 1);
    out_ready = 1'b1;
    send(9, 1, 4, 0);
    latency_check("postrst", 5);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    check("global_timeout", 0, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "global timeout");
  end

endmodule
